// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT output reorder stage.
//   NTT_Q   : default modulus for the optional final reduction
//   coeff_t : 32-bit coefficient word
//   bitrev  : reverses the low nbits of idx (upper bits of the result are zero)
package ntt_pkg;

  localparam int NTT_Q   = 7681;
  localparam int COEFF_W = 32;

  typedef logic [COEFF_W-1:0] coeff_t;

  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < nbits) r[nbits-1-i] = idx[i];
    return r;
  endfunction

endpackage

// File: rtl/ntt_reorder_bank.sv
// One frame buffer: DEPTH x W register array, one synchronous write port and
// one combinational read port. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data at raddr
module ntt_reorder_bank #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// Reorders bit-reversed NTT result frames into natural order through a
// ping-pong pair of radix-deep banks, and emits them over valid/ready.
// Upstream never stalls: in_ready is advisory, and a word arriving while the
// write bank is still full is dropped and flagged in the sticky overflow bit.
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid, in_data    : input word stream (bit-reversed frame order)
//   in_ready             : write bank has room
//   out_valid, out_data  : registered natural-order output word
//   out_ready            : consumer accepts when out_valid && out_ready
//   out_last             : out_data is word radix-1 of its frame
//   frame_done           : pulse on the handshake of the out_last beat
//   overflow             : sticky, a word was dropped
//
// Build option: define REORDER_FINAL_REDUCE_EN to apply one conditional
// subtract of Q to each word before it is written to a bank.
module ntt_bitrev_reorder
  import ntt_pkg::*;
#(
  parameter int W     = 32,
  parameter int radix = 16,
  parameter int Q     = NTT_Q
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         out_last,
  output logic         frame_done,
  output logic         overflow
);

  localparam int ADDR_WIDTH = $clog2(radix);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(radix - 1);

  logic                  wb, rb;
  logic [ADDR_WIDTH-1:0] wcnt, rcnt;
  logic [1:0]            full;
  logic [1:0][W-1:0]     bank_rd;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [W-1:0]          wdata;
  logic                  accept, wlast, load, rlast;

  assign in_ready   = !full[wb];
  assign accept     = in_valid && in_ready;
  assign wlast      = (wcnt == LAST_IDX);
  assign load       = full[rb] && (!out_valid || out_ready);
  assign rlast      = (rcnt == LAST_IDX);
  assign frame_done = out_valid && out_ready && out_last;
  assign waddr      = ADDR_WIDTH'(bitrev(32'(wcnt), ADDR_WIDTH));

`ifdef REORDER_FINAL_REDUCE_EN
  assign wdata = (in_data >= W'(Q)) ? in_data - W'(Q) : in_data;
`else
  // Q only matters for the reduced build; keep it referenced.
  logic unused_q;
  assign unused_q = ^W'(Q);
  assign wdata    = in_data;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ntt_reorder_bank #(.W(W), .DEPTH(radix), .AW(ADDR_WIDTH)) u_bank (
      .clk  (clk),
      .we   (accept && (wb == 1'(b))),
      .waddr(waddr),
      .wdata(wdata),
      .raddr(rcnt),
      .rdata(bank_rd[b])
    );
  end

  // Write completion sets full[wb] and read completion clears full[rb]; these
  // can coincide only when wb != rb, so the two bit updates never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb        <= 1'b0;
      rb        <= 1'b0;
      wcnt      <= '0;
      rcnt      <= '0;
      full      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        if (wlast) begin
          full[wb] <= 1'b1;
          wb       <= ~wb;
          wcnt     <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
      if (in_valid && !in_ready) overflow <= 1'b1;

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= bank_rd[rb];
        out_last  <= rlast;
        if (rlast) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
          rcnt     <= '0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
